// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: word width, owner tags
// and the address range check used on both request paths.
package mem_arbiter_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  function automatic logic in_range(input logic [WORD_W-1:0] addr, input int depth);
    return int'(addr) < depth;
  endfunction

endpackage

// File: rtl/starve_ctr.sv
// Counts consecutive cycles the fetch path is denied; raises f_prio once the
// count reaches STARVE_MAX so the next contested grant goes to fetch.
module starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic f_req,
  input  logic f_gnt,
  output logic f_prio
);

  logic [3:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 4'd0;
    end else if (!f_req || f_gnt) begin
      cnt_reg <= 4'd0;
    end else if (cnt_reg != 4'(STARVE_MAX)) begin
      cnt_reg <= cnt_reg + 4'd1;
    end
  end

  assign f_prio = (cnt_reg == 4'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch (read-only) and data
// (read/write) paths, one grant per cycle, routing read data back to its owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [WORD_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [WORD_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_err,
  output logic [WORD_W-1:0] mem_read_addr,
  output logic [WORD_W-1:0] mem_write_addr,
  output logic              mem_wr_enable,
  output logic [WORD_W-1:0] mem_wr_data,
  input  logic [WORD_W-1:0] mem_rd_data
);

  logic              f_prio;
  logic              f_sel;
  logic              d_sel;
  logic              f_oor;
  logic              d_oor;
  owner_t            owner_reg;
  owner_t            owner_next;
  logic              rd_oor_reg;
  logic              rd_oor_next;
  logic [WORD_W-1:0] rd_addr_reg;
  logic [WORD_W-1:0] wr_addr_reg;
  logic [WORD_W-1:0] f_hold_reg;
  logic [WORD_W-1:0] d_hold_reg;
  logic [WORD_W-1:0] ret_data;

  starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .f_req  (f_req),
    .f_gnt  (f_gnt),
    .f_prio (f_prio)
  );

  // Data path wins contention unless fetch has been starved long enough.
  assign f_sel = f_req & (~d_req | f_prio);
  assign d_sel = d_req & ~f_sel;
  assign f_gnt = rst_n & f_sel;
  assign d_gnt = rst_n & d_sel;

  assign f_oor = !in_range(f_addr, DEPTH);
  assign d_oor = !in_range(d_addr, DEPTH);

  assign d_err         = d_gnt & d_oor;
  assign mem_wr_enable = d_gnt & d_we & ~d_oor;
  assign mem_wr_data   = d_wdata;

  always_comb begin
    owner_next     = OWN_NONE;
    rd_oor_next    = 1'b0;
    mem_read_addr  = rd_addr_reg;
    mem_write_addr = wr_addr_reg;
    if (f_gnt) begin
      owner_next    = OWN_F;
      rd_oor_next   = f_oor;
      mem_read_addr = f_addr;
    end else if (d_gnt && !d_we) begin
      owner_next    = OWN_D;
      rd_oor_next   = d_oor;
      mem_read_addr = d_addr;
    end
    if (d_gnt && d_we) begin
      mem_write_addr = d_addr;
    end
  end

  // Out-of-range reads still return a beat, but with the memory data masked.
  assign ret_data = rd_oor_reg ? '0 : mem_rd_data;

  assign f_rvalid = (owner_reg == OWN_F);
  assign d_rvalid = (owner_reg == OWN_D);
  assign f_rdata  = f_rvalid ? ret_data : f_hold_reg;
  assign d_rdata  = d_rvalid ? ret_data : d_hold_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg   <= OWN_NONE;
      rd_oor_reg  <= 1'b0;
      rd_addr_reg <= '0;
      wr_addr_reg <= '0;
      f_hold_reg  <= '0;
      d_hold_reg  <= '0;
    end else begin
      owner_reg   <= owner_next;
      rd_oor_reg  <= rd_oor_next;
      rd_addr_reg <= mem_read_addr;
      wr_addr_reg <= mem_write_addr;
      if (f_rvalid) f_hold_reg <= ret_data;
      if (d_rvalid) d_hold_reg <= ret_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand-written
// starvation and reset sequences, with a read-return scoreboard.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [15:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  logic        d_err;
  logic [15:0] mem_read_addr;
  logic [15:0] mem_write_addr;
  logic        mem_wr_enable;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data;

  mem_arbiter #(.DEPTH(1024), .STARVE_MAX(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .f_req          (f_req),
    .f_addr         (f_addr),
    .f_gnt          (f_gnt),
    .f_rvalid       (f_rvalid),
    .f_rdata        (f_rdata),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_gnt          (d_gnt),
    .d_rvalid       (d_rvalid),
    .d_rdata        (d_rdata),
    .d_err          (d_err),
    .mem_read_addr  (mem_read_addr),
    .mem_write_addr (mem_write_addr),
    .mem_wr_enable  (mem_wr_enable),
    .mem_wr_data    (mem_wr_data),
    .mem_rd_data    (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached memory: registered read, one cycle latency.
  logic [15:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_wr_enable) mem[mem_write_addr[9:0]] <= mem_wr_data;
    mem_rd_data <= mem[mem_read_addr[9:0]];
  end

  logic [15:0] shadow [0:1023];

  function automatic logic [15:0] pattern(input int a);
    return 16'((a * 257) + 16'h1357);
  endfunction

  typedef struct {
    logic        fr;
    logic [15:0] fa;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [15:0] dwd;
    logic        efg;
    logic        edg;
    logic        ewe;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic        to_d;
    logic [15:0] data;
  } ret_t;

  vec_t        vecs[$];
  ret_t        sb[$];
  int          total;
  int          bad;
  logic [15:0] last_f;
  logic [15:0] last_d;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [15:0] a);
    return (a < 16'd1024) ? shadow[a[9:0]] : 16'h0000;
  endfunction

  task automatic drive(input logic fr, input logic [15:0] fa, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [15:0] dwd);
    f_req = fr; f_addr = fa; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
  endtask

  // One cycle: drive, then at the falling edge check returns and grants.
  task automatic step(input logic fr, input logic [15:0] fa, input logic dr, input logic dw,
                      input logic [15:0] da, input logic [15:0] dwd,
                      input logic efg, input logic edg, input logic ewe, input logic eerr);
    ret_t e;
    logic ef;
    logic ed;
    @(posedge clk);
    #1;
    drive(fr, fa, dr, dw, da, dwd);
    @(negedge clk);
    ef = 1'b0;
    ed = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.to_d) begin ed = 1'b1; last_d = e.data; end
      else        begin ef = 1'b1; last_f = e.data; end
    end
    chk("f_rvalid", 16'(f_rvalid), 16'(ef));
    chk("d_rvalid", 16'(d_rvalid), 16'(ed));
    chk("f_rdata", f_rdata, last_f);
    chk("d_rdata", d_rdata, last_d);
    chk("f_gnt", 16'(f_gnt), 16'(efg));
    chk("d_gnt", 16'(d_gnt), 16'(edg));
    chk("mem_wr_enable", 16'(mem_wr_enable), 16'(ewe));
    chk("d_err", 16'(d_err), 16'(eerr));
    if (ewe) begin
      chk("mem_write_addr", mem_write_addr, da);
      chk("mem_wr_data", mem_wr_data, dwd);
    end
    if (efg) begin
      chk("mem_read_addr_f", mem_read_addr, fa);
      sb.push_back('{to_d: 1'b0, data: exp_read(fa)});
    end
    if (edg && !dw) begin
      chk("mem_read_addr_d", mem_read_addr, da);
      sb.push_back('{to_d: 1'b1, data: exp_read(da)});
    end
    if (ewe) shadow[da[9:0]] = dwd;
    $display("cyc fr=%b fa=%h dr=%b dw=%b da=%h | fg=%b dg=%b we=%b err=%b fv=%b fd=%h dv=%b dd=%h",
             fr, fa, dr, dw, da, f_gnt, d_gnt, mem_wr_enable, d_err, f_rvalid, f_rdata, d_rvalid, d_rdata);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_f_gnt"}, 16'(f_gnt), 16'h0);
    chk({tag, "_d_gnt"}, 16'(d_gnt), 16'h0);
    chk({tag, "_wr_en"}, 16'(mem_wr_enable), 16'h0);
    chk({tag, "_d_err"}, 16'(d_err), 16'h0);
    chk({tag, "_f_rvalid"}, 16'(f_rvalid), 16'h0);
    chk({tag, "_d_rvalid"}, 16'(d_rvalid), 16'h0);
    chk({tag, "_f_rdata"}, f_rdata, 16'h0);
    chk({tag, "_d_rdata"}, d_rdata, 16'h0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    last_f = 16'h0;
    last_d = 16'h0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = pattern(i);
      shadow[i] = pattern(i);
    end
    mem[5]    = 16'hBEEF;
    shadow[5] = 16'hBEEF;

    //            fr    fa        dr    dw    da        dwd       efg   edg   ewe   eerr
    vecs.push_back('{1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'd1024,  16'hDEAD, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'd1024,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'd1024,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h03FF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h03FF, 16'hCAFE, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h03FF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0021, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h0022, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0023, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h0030, 1'b1, 1'b0, 16'h0031, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h0032, 1'b1, 1'b1, 16'h0033, 16'h5555, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 16'h0032, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0033, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});

    // Reset state, with both requests asserted to show grants are blocked.
    rst_n = 1'b0;
    drive(1'b1, 16'h0005, 1'b1, 1'b1, 16'h0010, 16'h7777);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dwd,
           vecs[i].efg, vecs[i].edg, vecs[i].ewe, vecs[i].eerr);
    end

    // Both requesting continuously: D four times, then F once, repeating.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'h0041, 1'b1, 1'b0, 16'h0040, 16'h0000,
           (i % 5) == 4, (i % 5) != 4, 1'b0, 1'b0);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset dropped the cycle after an F read grant: the return must vanish.
    step(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1'b1, 16'h0005, 1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    chk_reset_outputs("midrd_reset");
    sb.delete();
    last_f = 16'h0;
    last_d = 16'h0;
    @(posedge clk);
    #1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst_n = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
